// File: rtl/ahb_slave_arbiter.sv
//-----------------------------------------------------------------------------
// ahb_slave_arbiter
//
// Per-slave AHB arbiter. It chooses which of CHANNEL_NUM masters owns the
// slave port and keeps that choice stable for the whole of a transfer
// sequence: fixed-length bursts (4/8/16 beats, incrementing or wrapping),
// undefined-length INCR bursts and locked sequences. New grants are issued
// round-robin. The default build is complete without any macro.
//
// Build option:
//   AHB_ARB_FIXED_PRIO_EN - when defined, the lowest-index requester always
//                           wins and no round-robin pointer register exists.
//
// Parameters:
//   CHANNEL_NUM - number of competing masters (2..16)
//   BEAT_W      - width of the fixed-burst beat counter (must hold 15)
//
// Ports:
//   hclk       in   system clock, all state changes on the rising edge
//   hreset     in   synchronous active-high reset
//   req        in   per-master request for this slave
//   lock       in   per-master HMASTLOCK
//   htrans_sel in   HTRANS of the currently selected master
//   hburst_sel in   HBURST of the currently selected master
//   hready     in   slave HREADYOUT; address phase accepted when high
//   sel        out  one-hot address-phase grant (drives the request mux)
//   sel_data   out  one-hot data-phase owner (drives the response return)
//   grant_idx  out  binary index of sel
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_slave_arbiter #(
  parameter int CHANNEL_NUM = 2,
  parameter int BEAT_W      = 4
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [CHANNEL_NUM-1:0]         req,
  input  logic [CHANNEL_NUM-1:0]         lock,
  input  logic [1:0]                     htrans_sel,
  input  logic [2:0]                     hburst_sel,
  input  logic                           hready,
  output logic [CHANNEL_NUM-1:0]         sel,
  output logic [CHANNEL_NUM-1:0]         sel_data,
  output logic [$clog2(CHANNEL_NUM)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(CHANNEL_NUM);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_FIXED  = 2'd1,
    ST_INCR   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  // State to resume once a lock is released (burst context is kept).
  state_t                 ret_q, ret_d;
  logic [BEAT_W-1:0]      cnt_q, cnt_d;
  logic [CHANNEL_NUM-1:0] sel_q, sel_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;

  // ---------------------------------------------------------------------------
  // Decode of the selected master's transfer
  // ---------------------------------------------------------------------------
  logic              is_idle, is_busy, is_nonseq, is_seq;
  logic              burst_fixed, burst_incr;
  logic [BEAT_W-1:0] burst_load;
  logic              granted, lock_hit;

  assign is_idle   = (htrans_sel == HTRANS_IDLE);
  assign is_busy   = (htrans_sel == HTRANS_BUSY);
  assign is_nonseq = (htrans_sel == HTRANS_NONSEQ);
  assign is_seq    = (htrans_sel == HTRANS_SEQ);

  // HBURST[2:1] gives the length class for 4/8/16 beats, wrap or incr alike.
  assign burst_fixed = (hburst_sel[2:1] != 2'b00);
  assign burst_incr  = (hburst_sel == HBURST_INCR);

  always_comb begin
    burst_load = '0;
    case (hburst_sel[2:1])
      2'b01:   burst_load = BEAT_W'(3);
      2'b10:   burst_load = BEAT_W'(7);
      2'b11:   burst_load = BEAT_W'(15);
      default: burst_load = '0;
    endcase
  end

  // Before the first grant sel is all zero and nobody can hold the bus, so
  // neither a lock nor a burst start is attributed to master 0 by default.
  assign granted  = |sel_q;
  assign lock_hit = granted & lock[gidx_q];

  // ---------------------------------------------------------------------------
  // Winner search: rotate the request vector so that offset 0 is the master
  // at the search base, then take the lowest set offset.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]                  rr_base;
  logic [CHANNEL_NUM-1:0]            cand_req;
  logic [CHANNEL_NUM-1:0][IDX_W-1:0] cand_idx;
  logic                              win_found;
  logic [IDX_W-1:0]                  win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_rot
      logic [IDX_W:0] pos;
      assign pos          = {1'b0, rr_base} + (IDX_W+1)'(gi);
      // pos < 2*CHANNEL_NUM, so one conditional subtract is a full modulo.
      assign cand_idx[gi] = (pos >= (IDX_W+1)'(CHANNEL_NUM))
                            ? IDX_W'(pos - (IDX_W+1)'(CHANNEL_NUM))
                            : pos[IDX_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Scan downwards so the lowest offset is the last one written.
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic arb_point;
  logic arb_fire;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    sel_data_d = sel_data_q;
    gidx_d     = gidx_q;
    arb_point  = 1'b0;
    arb_fire   = 1'b0;

    // Wait states freeze everything, including the data-phase owner.
    if (hready) begin
      sel_data_d = sel_q;

      if (lock_hit) begin
        // Lock wins over everything else; the burst context is parked.
        if (state_q != ST_LOCKED) begin
          ret_d = state_q;
        end
        state_d = ST_LOCKED;
      end else begin
        case (state_q)
          ST_ARB: begin
            // A burst started by the current owner keeps its grant; any
            // other cycle here is a point where the grant may move.
            if (granted && is_nonseq && burst_fixed) begin
              cnt_d   = burst_load;
              state_d = ST_FIXED;
            end else if (granted && is_nonseq && burst_incr) begin
              state_d = ST_INCR;
            end else begin
              arb_point = 1'b1;
            end
          end

          ST_FIXED: begin
            if (is_seq) begin
              if (cnt_q <= BEAT_W'(1)) begin
                cnt_d   = '0;
                state_d = ST_ARB;
              end else begin
                cnt_d = cnt_q - BEAT_W'(1);
              end
            end else if (is_nonseq) begin
              // Early termination by a new transfer: re-arbitrate right now.
              cnt_d     = '0;
              state_d   = ST_ARB;
              arb_point = 1'b1;
            end else if (is_idle) begin
              cnt_d   = '0;
              state_d = ST_ARB;
            end
            // BUSY: count is held.
          end

          ST_INCR: begin
            if (is_idle || is_nonseq) begin
              state_d = ST_ARB;
            end
          end

          ST_LOCKED: begin
            // Lock released: resume whatever was in progress when it began.
            state_d = ret_q;
            ret_d   = ST_ARB;
          end

          default: begin
            state_d = ST_ARB;
          end
        endcase
      end

      if (arb_point && win_found) begin
        arb_fire        = 1'b1;
        sel_d           = '0;
        sel_d[win_idx]  = 1'b1;
        gidx_d          = win_idx;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_ARB;
      ret_q      <= ST_ARB;
      cnt_q      <= '0;
      sel_q      <= '0;
      sel_data_q <= '0;
      gidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      sel_data_q <= sel_data_d;
      gidx_q     <= gidx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Search base
  // ---------------------------------------------------------------------------
`ifdef AHB_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at master 0.
  assign rr_base = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] win_next;

  assign win_next = (win_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
  assign rr_d     = arb_fire ? win_next : rr_q;
  assign rr_base  = rr_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign sel       = sel_q;
  assign sel_data  = sel_data_q;
  assign grant_idx = gidx_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
//-----------------------------------------------------------------------------
// tb_ahb_slave_arbiter
//
// Stimulus is driven on the falling edge; at the same moment a behavioural
// model of the arbiter (owner / pointer / remaining beats, plain integers)
// predicts the outputs after the next rising edge and queues them. A separate
// monitor samples 1 ns after each rising edge and compares against the queue.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_slave_arbiter;

  localparam int N  = 2;
  localparam int IW = $clog2(N);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [1:0]    htrans_sel;
  logic [2:0]    hburst_sel;
  logic          hready;
  logic [N-1:0]  sel;
  logic [N-1:0]  sel_data;
  logic [IW-1:0] grant_idx;

  ahb_slave_arbiter #(
    .CHANNEL_NUM (N),
    .BEAT_W      (4)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .req        (req),
    .lock       (lock),
    .htrans_sel (htrans_sel),
    .hburst_sel (hburst_sel),
    .hready     (hready),
    .sel        (sel),
    .sel_data   (sel_data),
    .grant_idx  (grant_idx)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [N-1:0]  sel;
    logic [N-1:0]  sel_data;
    logic [IW-1:0] gidx;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   txn       = 0;
  bit   stim_done = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, where the next search starts, how many
  // SEQ beats a fixed burst still owes, whether an INCR burst is open, and
  // whether the owner holds a lock. All as plain integers.
  // ---------------------------------------------------------------------------
  int m_owner      = -1;
  int m_data_owner = -1;
  int m_rr         = 0;
  int m_beats      = 0;
  bit m_incr       = 1'b0;
  bit m_locked     = 1'b0;

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  function automatic void model_step(input logic rst, input logic [N-1:0] r,
                                     input logic [N-1:0] l, input logic [1:0] t,
                                     input logic [2:0] b, input logic rdy);
    bit arb;
    int w;
    int bi;
    if (rst) begin
      m_owner = -1; m_data_owner = -1; m_rr = 0;
      m_beats = 0;  m_incr = 1'b0;     m_locked = 1'b0;
      return;
    end
    if (!rdy) return;
    m_data_owner = m_owner;
    arb = 1'b0;
    bi  = int'(b);
    if (m_owner >= 0 && l[m_owner]) begin
      m_locked = 1'b1;
    end else if (m_locked) begin
      m_locked = 1'b0;
    end else if (m_beats > 0) begin
      if (t == T_SEQ) m_beats = m_beats - 1;
      else if (t == T_NONSEQ) begin m_beats = 0; arb = 1'b1; end
      else if (t == T_IDLE) m_beats = 0;
    end else if (m_incr) begin
      if (t == T_IDLE || t == T_NONSEQ) m_incr = 1'b0;
    end else if (m_owner >= 0 && t == T_NONSEQ && bi >= 2) begin
      m_beats = (4 << ((bi - 2) / 2)) - 1;
    end else if (m_owner >= 0 && t == T_NONSEQ && bi == 1) begin
      m_incr = 1'b1;
    end else begin
      arb = 1'b1;
    end
    if (arb) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && r[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      if (w >= 0) begin
        m_owner = w;
`ifndef AHB_ARB_FIXED_PRIO_EN
        m_rr = (w + 1) % N;
`endif
      end
    end
  endfunction

  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [1:0] t, input logic [2:0] b, input logic rdy);
    exp_t e;
    hreset     = rst;
    req        = r;
    lock       = l;
    htrans_sel = t;
    hburst_sel = b;
    hready     = rdy;
    model_step(rst, r, l, t, b, rdy);
    e.sel      = onehot(m_owner);
    e.sel_data = onehot(m_data_owner);
    e.gidx     = (m_owner >= 0) ? IW'(m_owner) : '0;
    exp_q.push_back(e);
    @(negedge hclk);
  endtask

  function automatic void check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, txn, act, req_v);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (exp_q.size() == 0) begin
        if (stim_done) break;
        checks++;
        failures++;
        $display("FAIL underflow txn=%0d got=empty expected=entry", txn);
      end else begin
        e = exp_q.pop_front();
        $display("txn %0d rst=%b req=%b lock=%b trans=%b burst=%0d rdy=%b -> sel=%b sel_data=%b gidx=%0d (exp %b %b %0d)",
                 txn, hreset, req, lock, htrans_sel, hburst_sel, hready,
                 sel, sel_data, grant_idx, e.sel, e.sel_data, e.gidx);
        check("sel",       int'(sel),       int'(e.sel));
        check("sel_data",  int'(sel_data),  int'(e.sel_data));
        check("grant_idx", int'(grant_idx), int'(e.gidx));
        txn++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog txn=%0d got=timeout expected=finish", txn);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    logic [N-1:0] r, l, lock_bits;
    logic [1:0]   t;
    logic [2:0]   b;
    logic         rdy, rst;
    int           lock_left;
    int           pick;

    // Reset
    step(1'b1, 2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    step(1'b1, 2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

    // Alternating SINGLE transfers with both masters requesting
    repeat (7) step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);

    // Master0 INCR4 with a BUSY and two wait states
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_INCR4,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR4,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_BUSY,   B_INCR4,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR4,  1'b0);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR4,  1'b0);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR4,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR4,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_IDLE,   B_SINGLE, 1'b1);

    // Master1 undefined-length INCR, 6 SEQ beats then IDLE
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_INCR, 1'b1);
    repeat (6) step(1'b0, 2'b11, 2'b00, T_SEQ, B_INCR, 1'b1);
    step(1'b0, 2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    step(1'b0, 2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

    // Master0 locked for 3 SINGLE transfers
    repeat (3) step(1'b0, 2'b11, 2'b01, T_NONSEQ, B_SINGLE, 1'b1);
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);

    // INCR8 terminated early by NONSEQ after 3 beats
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_INCR8,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR8,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_SEQ,    B_INCR8,  1'b1);
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);

    // Reset during beat 2 of INCR16, then contention again
    step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_INCR16, 1'b1);
    step(1'b1, 2'b11, 2'b00, T_SEQ,    B_INCR16, 1'b1);
    repeat (4) step(1'b0, 2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);

    // Randomised traffic
    lock_left = 0;
    lock_bits = '0;
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom);
      if (lock_left == 0 && $urandom_range(0, 19) == 0) begin
        lock_left = $urandom_range(1, 6);
        lock_bits = N'($urandom);
      end
      if (lock_left > 0) begin
        l = lock_bits;
        lock_left--;
      end else begin
        l = '0;
      end
      pick = $urandom_range(0, 9);
      if (pick < 2)      t = T_IDLE;
      else if (pick < 3) t = T_BUSY;
      else if (pick < 6) t = T_NONSEQ;
      else               t = T_SEQ;
      b   = 3'($urandom);
      rdy = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(rst, r, l, t, b, rdy);
    end

    stim_done = 1'b1;
    repeat (5) @(negedge hclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave AHB arbiter. It decides which of CHANNEL_NUM masters owns a slave port.
- Drives the one-hot `sel` consumed by the slave-side request mux, plus a data-phase-aligned select for the response return path.
- Grants are held across fixed-length bursts, undefined-length INCR bursts and locked sequences.
- Round-robin by default.

Parameters:
- CHANNEL_NUM, 2, number of masters competing for this slave (2..16).
- BEAT_W, 4, width of the burst beat counter (holds up to 15).

Ports:
- hclk  input  1  system clock; all state updates on rising edge.
- hreset  input  1  synchronous, active-high reset.
- req  input  CHANNEL_NUM  per-master bus request to this slave.
- lock  input  CHANNEL_NUM  per-master HMASTLOCK qualifier.
- htrans_sel  input  2  HTRANS of the currently selected master (mux output).
- hburst_sel  input  3  HBURST of the currently selected master.
- hready  input  1  slave HREADYOUT; an address phase is accepted when high.
- sel  output  CHANNEL_NUM  one-hot address-phase grant to the request mux.
- sel_data  output  CHANNEL_NUM  one-hot data-phase owner for response routing.
- grant_idx  output  $clog2(CHANNEL_NUM)  binary index of `sel`.

Behaviour:
- Reset values:
  - `sel` = 0, `sel_data` = 0, `grant_idx` = 0.
  - rr pointer = 0, beat counter = 0, state = ARB.
- All outputs are registered.
- Accept event: `hready`=1 and `htrans_sel` is NONSEQ (10) or SEQ (11).
- States:
  - ARB: a new grant may be issued.
  - FIXED: inside a 4/8/16-beat burst.
  - INCR: inside an undefined-length burst.
  - LOCKED.
- Arbitration point: `hready`=1 and state ARB (evaluated every cycle in ARB).
  - Winner: first `req` bit found scanning from the rr pointer upward with wrap-around.
  - `sel` takes the winner one-hot on the next edge.
  - rr pointer becomes (winner+1) mod CHANNEL_NUM.
  - If `req` is all zero, `sel` parks on its current value (stays 0 if never granted).
- Leaving ARB:
  - Accepted NONSEQ with `hburst_sel` INCR4/WRAP4 → load counter = 3, go FIXED.
  - Same for INCR8/WRAP8 with counter = 7, INCR16/WRAP16 with counter = 15.
  - INCR (001) → go INCR.
  - SINGLE → stay ARB.
- FIXED:
  - Each accepted SEQ decrements the counter.
  - When an accepted SEQ sees counter = 1 (last beat), return to ARB on the next edge.
  - BUSY holds the count.
  - Early termination (`hready`=1 with IDLE or NONSEQ) returns to ARB immediately. A NONSEQ there is treated as a fresh arbitration point in the same cycle.
- INCR: stay while `htrans_sel` is SEQ or BUSY; return to ARB on `hready`=1 with IDLE or NONSEQ.
- LOCKED:
  - Entered from any state when `hready`=1 and `lock[grant_idx]`=1.
  - No grant change while `lock[grant_idx]`=1.
  - On deassertion with `hready`=1, go to ARB, or to FIXED/INCR if a burst is still in progress (the counter is retained).
- `sel_data` <= `sel` on every edge with `hready`=1; it holds while `hready`=0 (wait states).
- `hready`=0 freezes the state, counter, `sel` and rr pointer.
- A request dropped mid-burst is ignored until the next arbitration point.
- Simultaneous requests are resolved purely by the rr pointer.
- Reset asserted mid-burst returns everything to the reset values on the next edge.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index requesting master wins at every arbitration point; the rr pointer is not implemented and stays 0.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then `req`=2'b11 with SINGLE NONSEQ and `hready`=1 every cycle → `sel` alternates 01,10,01,10 from the first edge after reset release; `sel_data` follows one cycle later.
- Master0 starts INCR4 while `req`=11 → `sel`=01 held for 4 accepted beats, including one BUSY and 2 `hready`=0 wait cycles; `sel`=10 on the edge after the 4th beat.
- Master1 INCR burst of 6 SEQ beats, then IDLE, with `req`=11 → `sel`=10 throughout; switches to 01 on the edge after IDLE is accepted.
- `lock[0]`=1 for 3 SINGLE transfers while `req`=11 → `sel` stays 01; switches to 10 after `lock[0]` drops with `hready`=1.
- INCR8 early-terminated by NONSEQ after 3 beats → state returns to ARB, counter cleared, rr arbitration occurs on that cycle.
- Reset asserted during beat 2 of INCR16 → `sel`=0, `sel_data`=0, state ARB next edge; with AHB_ARB_FIXED_PRIO_EN and `req`=11, master0 wins repeatedly.
